// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel prefetch path.
// The pixel word layout, the default frame geometry and the prefetch
// FSM state type all live here so every file agrees on them.
package vga_pkg;

    // One 24-bit pixel, red in the top byte.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Default visible frame geometry.
    localparam int H_ACTIVE         = 640;
    localparam int V_ACTIVE         = 480;
    localparam int FB_WORDS_DEFAULT = H_ACTIVE * V_ACTIVE;

    // Prefetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pf_state_t;

    // Sixteen-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end
        return value + 16'd1;
    endfunction

endpackage

// File: rtl/vga_pixel_prefetch_if.sv
// Signal bundle between the pixel prefetcher, the framebuffer read port
// and the VGA controller. The prefetcher uses the slave view; whatever
// drives frame starts, pixel requests and memory data uses the master view.
interface vga_pixel_prefetch_if
    import vga_pkg::*;
#(
    parameter int FB_AW = 19
);

    logic             iFRAME_START;
    logic             iREAD;
    rgb_t             oRGB;
    logic             oMEM_RD;
    logic [FB_AW-1:0] oMEM_ADDR;
    rgb_t             iMEM_DATA;
    logic             oUNDERFLOW;
    logic [15:0]      oUNDER_CNT;

    modport master (
        output iFRAME_START,
        output iREAD,
        output iMEM_DATA,
        input  oRGB,
        input  oMEM_RD,
        input  oMEM_ADDR,
        input  oUNDERFLOW,
        input  oUNDER_CNT
    );

    modport slave (
        input  iFRAME_START,
        input  iREAD,
        input  iMEM_DATA,
        output oRGB,
        output oMEM_RD,
        output oMEM_ADDR,
        output oUNDERFLOW,
        output oUNDER_CNT
    );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding prefetched pixels.
// Pointers wrap naturally because DEPTH is a power of two; the separate
// occupancy count distinguishes full from empty. A flush empties the
// queue in one cycle and takes priority over push and pop.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/vga_pixel_prefetch.sv
// Streams one frame of pixels from a fixed-latency framebuffer into a
// prefetch FIFO and hands them to the VGA controller one per request.
// Reads are only issued while queued plus in-flight pixels fit in the
// FIFO, so returning data always has a slot. A frame-start pulse flushes
// everything, including reads still in memory, and restarts at address 0.
module vga_pixel_prefetch
    import vga_pkg::*;
#(
    parameter int FB_AW    = 19,
    parameter int FB_WORDS = FB_WORDS_DEFAULT,
    parameter int MEM_LAT  = 2,
    parameter int DEPTH    = 16
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST_n,
    vga_pixel_prefetch_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    pf_state_t        state;
    pf_state_t        state_next;
    logic [FB_AW-1:0] rd_addr;
    logic [MEM_LAT-1:0] tags;

    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [23:0]      fifo_head;
    logic             fifo_push;
    logic             fifo_pop;

    logic             frame_start;
    logic             read_req;
    logic             issue;
    logic             last_addr;
    logic [OW-1:0]    inflight;
    logic [OW-1:0]    occupancy;

    rgb_t             rgb_q;
    logic             underflow_q;
    logic [15:0]      under_cnt_q;

    assign frame_start = bus.iFRAME_START;
    assign read_req    = bus.iREAD && !frame_start;
    assign last_addr   = (rd_addr == FB_AW'(FB_WORDS - 1));
    assign inflight    = OW'($countones(tags));
    assign occupancy   = OW'(fifo_count) + inflight;
    assign fifo_push   = tags[MEM_LAT-1] && !frame_start;
    assign fifo_pop    = read_req && !fifo_empty;

    assign bus.oMEM_RD    = issue;
    assign bus.oMEM_ADDR  = rd_addr;
    assign bus.oRGB       = rgb_q;
    assign bus.oUNDERFLOW = underflow_q;
    assign bus.oUNDER_CNT = under_cnt_q;

    // Sequencer state register.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and read issue; a frame start always restarts and issues nothing that cycle.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        if (frame_start) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                RUN: begin
                    if (iRST_n && (occupancy < OW'(DEPTH))) begin
                        issue = 1'b1;
                        if (last_addr) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Read address and in-flight tag pipe; the tag leaving the pipe marks valid memory data.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            rd_addr <= '0;
            tags    <= '0;
        end else if (frame_start) begin
            rd_addr <= '0;
            tags    <= '0;
        end else begin
            tags <= (tags << 1) | MEM_LAT'(issue);
            if (issue && !last_addr) begin
                rd_addr <= rd_addr + FB_AW'(1);
            end
        end
    end

    // Pixel output, sticky underflow and saturating underflow counter.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            rgb_q       <= '0;
            underflow_q <= 1'b0;
            under_cnt_q <= '0;
        end else if (frame_start) begin
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else if (read_req) begin
            if (!fifo_empty) begin
                rgb_q <= rgb_t'(fifo_head);
            end else begin
                rgb_q       <= '0;
                underflow_q <= 1'b1;
                under_cnt_q <= sat_inc16(under_cnt_q);
            end
        end
    end

    // The issue throttle must make a push into a full FIFO impossible.
    always_ff @(posedge iVGA_CLK) begin
        if (iRST_n) begin
            assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk   (iVGA_CLK),
        .rst_n (iRST_n),
        .push  (fifo_push),
        .din   (bus.iMEM_DATA),
        .pop   (fifo_pop),
        .flush (frame_start),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Bench for vga_pixel_prefetch with a small frame. A memory model answers
// reads with data equal to the address. A queue-based reference model
// predicts read strobes and pixel outputs; two monitors pop and compare.
module tb_vga_pixel_prefetch;
    import vga_pkg::*;

    localparam int AW  = 19;
    localparam int FBW = 1000;
    localparam int LAT = 2;
    localparam int DEP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vga_pixel_prefetch_if #(.FB_AW(AW)) bus ();

    vga_pixel_prefetch #(
        .FB_AW    (AW),
        .FB_WORDS (FBW),
        .MEM_LAT  (LAT),
        .DEPTH    (DEP)
    ) dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .bus      (bus)
    );

    // Framebuffer model: fixed latency, data = address, junk when idle.
    logic          mv [LAT];
    logic [AW-1:0] ma [LAT];
    logic [23:0]   junk;

    always @(posedge clk) begin
        mv[0] <= bus.oMEM_RD;
        ma[0] <= bus.oMEM_ADDR;
        for (int i = 1; i < LAT; i++) begin
            mv[i] <= mv[i-1];
            ma[i] <= ma[i-1];
        end
        junk <= 24'($urandom);
    end

    assign bus.iMEM_DATA = mv[LAT-1] ? rgb_t'(24'(ma[LAT-1])) : rgb_t'(junk);

    // Scoreboard state.
    typedef struct { logic [23:0] data; longint due; } flight_t;
    typedef struct { bit rd; int addr; } mem_exp_t;
    typedef struct { logic [23:0] rgb; bit uf; logic [15:0] cnt; } out_exp_t;

    flight_t     flight_q [$];
    logic [23:0] fifo_m [$];
    mem_exp_t    mem_q [$];
    out_exp_t    out_q [$];

    bit          m_running;
    int          m_next;
    logic [23:0] m_rgb;
    bit          m_uf;
    int          m_cnt;
    longint      cyc;

    int checks = 0;
    int errors = 0;
    int rd_seen = 0;
    int max_addr = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model step for one cycle given that cycle's inputs.
    function automatic void model_step(input bit fs, input bit rd, input bit rst);
        mem_exp_t me;
        out_exp_t oe;
        flight_t  f;
        bit       iss;
        if (!rst) begin
            fifo_m.delete();
            flight_q.delete();
            m_running = 0;
            m_next    = 0;
            m_rgb     = '0;
            m_uf      = 0;
            m_cnt     = 0;
            me.rd     = 0;
            me.addr   = 0;
        end else begin
            iss     = m_running && !fs && ((fifo_m.size() + flight_q.size()) < DEP);
            me.rd   = iss;
            me.addr = m_next;
            if (fs) begin
                m_rgb = '0;
                m_uf  = 0;
            end else if (rd) begin
                if (fifo_m.size() > 0) begin
                    m_rgb = fifo_m.pop_front();
                end else begin
                    m_rgb = '0;
                    m_uf  = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (flight_q.size() > 0 && flight_q[0].due == cyc) begin
                f = flight_q.pop_front();
                fifo_m.push_back(f.data);
            end
            if (iss) begin
                f.data = 24'(m_next);
                f.due  = cyc + LAT;
                flight_q.push_back(f);
                if (m_next == FBW - 1) m_running = 0;
                else m_next++;
            end
            if (fs) begin
                fifo_m.delete();
                flight_q.delete();
                m_running = 1;
                m_next    = 0;
            end
        end
        oe.rgb = m_rgb;
        oe.uf  = m_uf;
        oe.cnt = 16'(m_cnt);
        mem_q.push_back(me);
        out_q.push_back(oe);
    endfunction

    task automatic apply_stimulus(input bit fs, input bit rd, input bit rst);
        @(negedge clk);
        rst_n            = rst;
        bus.iFRAME_START = fs;
        bus.iREAD        = rd;
        model_step(fs, rd, rst);
        cyc++;
    endtask

    // Read-strobe monitor, sampled just before the rising edge.
    initial begin
        mem_exp_t me;
        forever begin
            @(negedge clk);
            #4;
            if (mem_q.size() > 0) begin
                me = mem_q.pop_front();
                check_output("mem_rd", 32'(bus.oMEM_RD), 32'(me.rd));
                if (me.rd) check_output("mem_addr", 32'(bus.oMEM_ADDR), 32'(me.addr));
                if (bus.oMEM_RD) begin
                    rd_seen++;
                    if (int'(bus.oMEM_ADDR) > max_addr) max_addr = int'(bus.oMEM_ADDR);
                end
            end
        end
    end

    // Pixel output monitor, sampled just after the rising edge.
    initial begin
        out_exp_t oe;
        forever begin
            @(posedge clk);
            #1;
            if (out_q.size() > 0) begin
                oe = out_q.pop_front();
                check_output("rgb", 32'(bus.oRGB), 32'(oe.rgb));
                check_output("underflow", 32'(bus.oUNDERFLOW), 32'(oe.uf));
                check_output("under_cnt", 32'(bus.oUNDER_CNT), 32'(oe.cnt));
            end
        end
    end

    initial begin
        cyc = 0;
        bus.iFRAME_START = 1'b0;
        bus.iREAD        = 1'b0;

        // Reset, then idle: no reads expected.
        repeat (3) apply_stimulus(0, 0, 0);
        repeat (3) apply_stimulus(0, 0, 1);

        // Frame start with no requests: FIFO fills with exactly DEPTH reads.
        rd_seen = 0;
        apply_stimulus(1, 0, 1);
        repeat (20) apply_stimulus(0, 0, 1);
        @(posedge clk);
        check_output("fill_reads", 32'(rd_seen), 32'(DEP));

        // Continuous requests stream pixels in address order.
        repeat (640) apply_stimulus(0, 1, 1);
        repeat (2) apply_stimulus(0, 0, 1);

        // Request one cycle after frame start: first pixel underflows.
        apply_stimulus(0, 0, 0);
        apply_stimulus(1, 0, 1);
        apply_stimulus(0, 1, 1);
        @(posedge clk);
        #2;
        check_output("first_underflow_cnt", 32'(bus.oUNDER_CNT), 32'd1);
        repeat (30) apply_stimulus(0, 1, 1);

        // Restart with reads queued and in flight, including a coincident request.
        apply_stimulus(1, 0, 1);
        repeat (12) apply_stimulus(0, 0, 1);
        apply_stimulus(1, 1, 1);
        repeat (40) apply_stimulus(0, 1, 1);

        // Randomized traffic with occasional frame starts.
        for (int i = 0; i < 2500; i++) begin
            apply_stimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 60), 1);
        end

        // Whole frame plus five extra requests.
        apply_stimulus(0, 0, 0);
        max_addr = 0;
        apply_stimulus(1, 0, 1);
        repeat (20) apply_stimulus(0, 0, 1);
        repeat (FBW + 5) apply_stimulus(0, 1, 1);
        repeat (2) apply_stimulus(0, 0, 1);
        @(posedge clk);
        #2;
        check_output("frame_end_under_cnt", 32'(bus.oUNDER_CNT), 32'd5);
        check_output("addr_bound", 32'(max_addr), 32'(FBW - 1));

        // Reset mid-frame: everything clears and no reads until the next frame start.
        apply_stimulus(1, 0, 1);
        repeat (8) apply_stimulus(0, 1, 1);
        apply_stimulus(0, 0, 0);
        rd_seen = 0;
        repeat (10) apply_stimulus(0, 1, 1);
        @(posedge clk);
        check_output("no_reads_after_reset", 32'(rd_seen), 32'd0);

        repeat (2) apply_stimulus(0, 0, 1);
        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
